// File: rtl/rotary_pkg.sv
// Shared types for the rotary encoder controller: quadrature phase, step direction
// and the phase-neighbour decode used by the phase FSM.
package rotary_pkg;

  typedef enum logic [1:0] {
    P00 = 2'b00,
    P10 = 2'b10,
    P11 = 2'b11,
    P01 = 2'b01
  } phase_t;

  // DIR_ILL marks a jump to the opposite corner (both channels changed at once).
  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW,
    DIR_ILL
  } dir_t;

  function automatic dir_t next_dir(input phase_t cur, input logic [1:0] ab);
    phase_t cw_nb;
    phase_t ccw_nb;
    case (cur)
      P00:     begin cw_nb = P10; ccw_nb = P01; end
      P10:     begin cw_nb = P11; ccw_nb = P00; end
      P11:     begin cw_nb = P01; ccw_nb = P10; end
      default: begin cw_nb = P00; ccw_nb = P11; end
    endcase
    if (ab == cur)         return DIR_NONE;
    else if (ab == cw_nb)  return DIR_CW;
    else if (ab == ccw_nb) return DIR_CCW;
    else                   return DIR_ILL;
  endfunction

endpackage

// File: rtl/rotary_ctrl_quad_filter.sv
// One encoder channel: two-flop synchroniser followed by a stability filter that
// only follows the input after it has differed for FILT_LEN consecutive edges.
module quad_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_filt
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic sync1;
  logic sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      d_filt <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= d_in;
      sync2 <= sync1;
      // Any return to the filtered level restarts the count, discarding short pulses.
      if (sync2 == d_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        d_filt <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rotary_ctrl.sv
// Rotary encoder controller: filtered quadrature phase tracking, detent
// accumulation and a bounded position register with saturate/wrap policy.
module rotary_ctrl
  import rotary_pkg::*;
#(
  parameter int POS_W            = 8,
  parameter int FILT_LEN         = 4,
  parameter int EDGES_PER_DETENT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic [POS_W-1:0] cfg_min,
  input  logic [POS_W-1:0] cfg_max,
  input  logic             cfg_wrap,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             err
);

  localparam int SUB_W = $clog2(EDGES_PER_DETENT) + 2;
  localparam logic signed [SUB_W-1:0] SUB_ONE = SUB_W'(1);
  localparam logic signed [SUB_W-1:0] SUB_TOP = SUB_W'(EDGES_PER_DETENT - 1);
  localparam logic signed [SUB_W-1:0] SUB_BOT = -SUB_TOP;

  logic                    filt_a;
  logic                    filt_b;
  logic [1:0]              ab;
  phase_t                  phase;
  dir_t                    dir;
  logic signed [SUB_W-1:0] sub;
  logic                    cw_done;
  logic                    ccw_done;

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk    (clk),
    .rst    (rst),
    .d_in   (a_in),
    .d_filt (filt_a)
  );

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk    (clk),
    .rst    (rst),
    .d_in   (b_in),
    .d_filt (filt_b)
  );

  assign ab       = {filt_a, filt_b};
  assign dir      = next_dir(phase, ab);
  assign cw_done  = (dir == DIR_CW)  && (sub == SUB_TOP);
  assign ccw_done = (dir == DIR_CCW) && (sub == SUB_BOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= P00;
      sub      <= '0;
      pos      <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      err      <= 1'b0;
    end else if (clr) begin
      // Resync the phase to the filtered pins so the clear itself never counts.
      phase    <= phase_t'(ab);
      sub      <= '0;
      pos      <= cfg_min;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      err      <= 1'b0;
    end else begin
      step_cw  <= cw_done;
      step_ccw <= ccw_done;
      if (dir != DIR_NONE) phase <= phase_t'(ab);
      if (dir == DIR_ILL)  err   <= 1'b1;

      if (cw_done || ccw_done) sub <= '0;
      else if (dir == DIR_CW)  sub <= sub + SUB_ONE;
      else if (dir == DIR_CCW) sub <= sub - SUB_ONE;

      // Clamping after a bounds change wins over a step landing in the same cycle.
      if (pos > cfg_max)      pos <= cfg_max;
      else if (pos < cfg_min) pos <= cfg_min;
      else if (cw_done)       pos <= (pos == cfg_max) ? (cfg_wrap ? cfg_min : pos) : pos + 1'b1;
      else if (ccw_done)      pos <= (pos == cfg_min) ? (cfg_wrap ? cfg_max : pos) : pos - 1'b1;
    end
  end

endmodule
